jtag_tap_ctrl_os: RTL and testbench

// - Oversampled IEEE 1149.1 TAP controller running entirely in the system clk domain.
// - Sits directly downstream of the TCK edge detector; consumes its one-cycle TCK rise/fall pulses.
// - Also consumes 2FF-synchronised TMS/TDI.
// - Holds the 16-state TAP FSM, IR, BYPASS and optional IDCODE DRs; exposes a user-DR strobe interface.

---
 rtl/jtag_tap_ctrl_os_if.sv | 32 +++
 rtl/jtag_tap_ctrl_os.sv | 159 +++++++++++++++
 tb/tb_jtag_tap_ctrl_os.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_tap_ctrl_os_if.sv
// TAP controller signal bundle: TCK edge strobes and synchronised pins in,
// serial out, state/instruction visibility and the user-DR strobe group.
interface jtag_tap_ctrl_os_if #(
   parameter int IR_WIDTH = 4
);
   logic                tck_rise;
   logic                tck_fall;
   logic                tms;
   logic                tdi;
   logic                tdo;
   logic                tdo_oe;
   logic [3:0]          tap_state;
   logic [IR_WIDTH-1:0] ir_out;
   logic                udr_capture;
   logic                udr_shift;
   logic                udr_update;
   logic                udr_tdo;

   // Strobe semantics: tck_rise/tck_fall are single-clk qualifiers with no
   // back-pressure; tms/tdi are consumed only in a tck_rise cycle, udr_tdo
   // only in a tck_fall cycle, and each udr_* strobe is valid for exactly
   // the one clk in which it is high.
   modport slave (
      input  tck_rise, tck_fall, tms, tdi, udr_tdo,
      output tdo, tdo_oe, tap_state, ir_out, udr_capture, udr_shift, udr_update
   );

   modport master (
      output tck_rise, tck_fall, tms, tdi, udr_tdo,
      input  tdo, tdo_oe, tap_state, ir_out, udr_capture, udr_shift, udr_update
   );
endinterface

// File: rtl/jtag_tap_ctrl_os.sv
// Oversampled IEEE 1149.1 TAP controller in the clk domain, driven by TCK edge
// strobes. Define JTAG_TAP_IDCODE_EN to include the 32-bit IDCODE data register.
module jtag_tap_ctrl_os #(
   parameter int                  IR_WIDTH     = 4,
   parameter logic [IR_WIDTH-1:0] IDCODE_INSTR = IR_WIDTH'(1),
   parameter logic [31:0]         IDCODE_VAL   = 32'h1000_0001
) (
   input logic               clk,
   input logic               rst_n,
   jtag_tap_ctrl_os_if.slave bus
);

   typedef enum logic [3:0] {
      EXIT2_DR   = 4'h0,
      EXIT1_DR   = 4'h1,
      SHIFT_DR   = 4'h2,
      PAUSE_DR   = 4'h3,
      SELECT_IR  = 4'h4,
      UPDATE_DR  = 4'h5,
      CAPTURE_DR = 4'h6,
      SELECT_DR  = 4'h7,
      EXIT2_IR   = 4'h8,
      EXIT1_IR   = 4'h9,
      SHIFT_IR   = 4'hA,
      PAUSE_IR   = 4'hB,
      RUN_IDLE   = 4'hC,
      UPDATE_IR  = 4'hD,
      CAPTURE_IR = 4'hE,
      TEST_RESET = 4'hF
   } tap_state_e;

   localparam logic [IR_WIDTH-1:0] BYPASS_INSTR = '1;
   localparam logic [IR_WIDTH-1:0] IR_CAPTURE   = IR_WIDTH'(2'b01);
`ifdef JTAG_TAP_IDCODE_EN
   localparam logic [IR_WIDTH-1:0] RESET_INSTR  = IDCODE_INSTR;
`else
   localparam logic [IR_WIDTH-1:0] RESET_INSTR  = BYPASS_INSTR;
`endif

   if (IR_WIDTH < 2 || IDCODE_VAL[0] != 1'b1 || IDCODE_INSTR == BYPASS_INSTR) begin : g_bad_cfg
      $error("jtag_tap_ctrl_os: invalid parameter set");
   end

   tap_state_e          state_q, state_d;
   logic [IR_WIDTH-1:0] ir_q, ir_sreg;
   logic                bypass_q;
   logic                tdo_q, tdo_oe_q, tdo_src;
   logic                rise_evt, fall_evt;
   logic                sel_bypass, sel_idcode, sel_user;
   logic                udr_capture, udr_shift, udr_update;

   // A fall coincident with a rise is an edge-detector fault; the rise wins.
   assign rise_evt = bus.tck_rise;
   assign fall_evt = bus.tck_fall & ~bus.tck_rise;

`ifdef JTAG_TAP_IDCODE_EN
   logic [31:0] idcode_sreg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idcode_sreg <= '0;
      end else if (rise_evt && sel_idcode) begin
         if (state_q == CAPTURE_DR) idcode_sreg <= IDCODE_VAL;
         else if (state_q == SHIFT_DR) idcode_sreg <= {bus.tdi, idcode_sreg[31:1]};
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= TEST_RESET;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (rise_evt) begin
         case (state_q)
            TEST_RESET: state_d = bus.tms ? TEST_RESET : RUN_IDLE;
            RUN_IDLE:   state_d = bus.tms ? SELECT_DR  : RUN_IDLE;
            SELECT_DR:  state_d = bus.tms ? SELECT_IR  : CAPTURE_DR;
            CAPTURE_DR: state_d = bus.tms ? EXIT1_DR   : SHIFT_DR;
            SHIFT_DR:   state_d = bus.tms ? EXIT1_DR   : SHIFT_DR;
            EXIT1_DR:   state_d = bus.tms ? UPDATE_DR  : PAUSE_DR;
            PAUSE_DR:   state_d = bus.tms ? EXIT2_DR   : PAUSE_DR;
            EXIT2_DR:   state_d = bus.tms ? UPDATE_DR  : SHIFT_DR;
            UPDATE_DR:  state_d = bus.tms ? SELECT_DR  : RUN_IDLE;
            SELECT_IR:  state_d = bus.tms ? TEST_RESET : CAPTURE_IR;
            CAPTURE_IR: state_d = bus.tms ? EXIT1_IR   : SHIFT_IR;
            SHIFT_IR:   state_d = bus.tms ? EXIT1_IR   : SHIFT_IR;
            EXIT1_IR:   state_d = bus.tms ? UPDATE_IR  : PAUSE_IR;
            PAUSE_IR:   state_d = bus.tms ? EXIT2_IR   : PAUSE_IR;
            EXIT2_IR:   state_d = bus.tms ? UPDATE_IR  : SHIFT_IR;
            UPDATE_IR:  state_d = bus.tms ? SELECT_DR  : RUN_IDLE;
            default:    state_d = TEST_RESET;
         endcase
      end
   end

   // Data-register decode and the per-clk outputs derived from it.
   always_comb begin
      sel_bypass = (ir_q == BYPASS_INSTR);
`ifdef JTAG_TAP_IDCODE_EN
      sel_idcode = (ir_q == IDCODE_INSTR);
`else
      sel_idcode = 1'b0;
`endif
      sel_user    = !sel_bypass && !sel_idcode;
      udr_capture = rise_evt && sel_user && (state_q == CAPTURE_DR);
      udr_shift   = rise_evt && sel_user && (state_q == SHIFT_DR);
      udr_update  = fall_evt && sel_user && (state_q == UPDATE_DR);
      tdo_src     = bypass_q;
      if (state_q == SHIFT_IR) tdo_src = ir_sreg[0];
      else if (sel_user)       tdo_src = bus.udr_tdo;
`ifdef JTAG_TAP_IDCODE_EN
      else if (sel_idcode)     tdo_src = idcode_sreg[0];
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_q     <= RESET_INSTR;
         ir_sreg  <= '0;
         bypass_q <= 1'b0;
         tdo_q    <= 1'b0;
         tdo_oe_q <= 1'b0;
      end else if (rise_evt) begin
         if (state_d == TEST_RESET) ir_q <= RESET_INSTR;
         case (state_q)
            CAPTURE_IR: ir_sreg <= IR_CAPTURE;
            SHIFT_IR:   ir_sreg <= {bus.tdi, ir_sreg[IR_WIDTH-1:1]};
            CAPTURE_DR: if (sel_bypass) bypass_q <= 1'b0;
            SHIFT_DR:   if (sel_bypass) bypass_q <= bus.tdi;
            default: ;
         endcase
      end else if (fall_evt) begin
         if (state_q == UPDATE_IR) ir_q <= ir_sreg;
         tdo_q    <= tdo_src;
         tdo_oe_q <= (state_q == SHIFT_DR) || (state_q == SHIFT_IR);
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rst_n) begin
         assert (!(bus.tck_rise && bus.tck_fall))
            else $warning("jtag_tap_ctrl_os: tck_rise and tck_fall in one clk, fall dropped");
      end
   end
`endif

   assign bus.tap_state   = state_q;
   assign bus.ir_out      = ir_q;
   assign bus.tdo         = tdo_q;
   assign bus.tdo_oe      = tdo_oe_q;
   assign bus.udr_capture = udr_capture;
   assign bus.udr_shift   = udr_shift;
   assign bus.udr_update  = udr_update;

endmodule

// File: tb/tb_jtag_tap_ctrl_os.sv
// Directed bench for jtag_tap_ctrl_os: reset, IDCODE stream, bypass delay,
// IR load, user-DR strobes, edge collision and reset during Shift-DR.
module tb_jtag_tap_ctrl_os;
  localparam int IRW = 4;
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [3:0] RST_IR = 4'b0001;
`else
  localparam logic [3:0] RST_IR = 4'b1111;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int cap_cnt = 0;
  int shf_cnt = 0;
  int upd_cnt = 0;
  logic [31:0] exp_q[$];
  logic [3:0] cur_ir;

  jtag_tap_ctrl_os_if #(.IR_WIDTH(IRW)) bus ();

  jtag_tap_ctrl_os #(
    .IR_WIDTH(IRW),
    .IDCODE_INSTR(4'b0001),
    .IDCODE_VAL(32'h1000_0001)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // udr strobe monitor, sampled mid-cycle; a wide pulse counts more than once
  always @(negedge clk) begin
    if (bus.udr_capture) cap_cnt++;
    if (bus.udr_shift) shf_cnt++;
    if (bus.udr_update) upd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_tdo(input string tag);
    logic [31:0] e;
    e = exp_q.pop_front();
    check(tag, 32'(bus.tdo), e);
  endtask

  // driver tasks: called at posedge+1, return at the following posedge+1
  task automatic rise(input logic m, input logic d);
    bus.tms = m;
    bus.tdi = d;
    bus.tck_rise = 1'b1;
    @(posedge clk);
    #1;
    bus.tck_rise = 1'b0;
  endtask

  task automatic fall();
    bus.tck_fall = 1'b1;
    @(posedge clk);
    #1;
    bus.tck_fall = 1'b0;
  endtask

  task automatic both(input logic m, input logic d);
    bus.tms = m;
    bus.tdi = d;
    bus.tck_rise = 1'b1;
    bus.tck_fall = 1'b1;
    @(posedge clk);
    #1;
    bus.tck_rise = 1'b0;
    bus.tck_fall = 1'b0;
  endtask

  // from Run-Test/Idle: load v through Shift-IR, return to Run-Test/Idle
  task automatic load_ir(input logic [3:0] v);
    rise(1'b1, 1'b0);
    rise(1'b1, 1'b0);
    rise(1'b0, 1'b0);
    rise(1'b0, 1'b0);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    for (int i = 0; i < 4; i++) begin
      fall();
      check("ir_shift_oe", 32'(bus.tdo_oe), 32'd1);
      check_tdo("ir_shift_tdo");
      rise(i == 3, v[i]);
    end
    rise(1'b1, 1'b0);
    check("ir_hold_before_update", 32'(bus.ir_out), 32'(cur_ir));
    fall();
    check("ir_update", 32'(bus.ir_out), 32'(v));
    check("ir_oe_off", 32'(bus.tdo_oe), 32'd0);
    cur_ir = v;
    rise(1'b0, 1'b0);
    check("ir_back_to_rti", 32'(bus.tap_state), 32'hC);
  endtask

  initial begin
    logic [31:0] idv;
    logic [3:0] pat;
    bus.tck_rise = 1'b0;
    bus.tck_fall = 1'b0;
    bus.tms = 1'b0;
    bus.tdi = 1'b0;
    bus.udr_tdo = 1'b0;
    cur_ir = RST_IR;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(bus.tap_state), 32'hF);
    check("rst_ir", 32'(bus.ir_out), 32'(RST_IR));
    check("rst_tdo", 32'(bus.tdo), 32'd0);
    check("rst_tdo_oe", 32'(bus.tdo_oe), 32'd0);
    check("rst_udr", 32'({bus.udr_capture, bus.udr_shift, bus.udr_update}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    repeat (5) rise(1'b1, 1'b0);
    check("tlr_state", 32'(bus.tap_state), 32'hF);
    check("tlr_ir", 32'(bus.ir_out), 32'(RST_IR));
    rise(1'b0, 1'b0);
    check("rti_state", 32'(bus.tap_state), 32'hC);

`ifdef JTAG_TAP_IDCODE_EN
    rise(1'b1, 1'b0);
    rise(1'b0, 1'b0);
    rise(1'b0, 1'b0);
    check("idc_shift_state", 32'(bus.tap_state), 32'h2);
    idv = 32'h1000_0001;
    for (int i = 0; i < 32; i++) exp_q.push_back(32'(idv[i]));
    for (int i = 0; i < 32; i++) begin
      fall();
      check("idc_oe", 32'(bus.tdo_oe), 32'd1);
      check_tdo("idc_tdo");
      rise(i == 31, 1'b0);
    end
    rise(1'b1, 1'b0);
    fall();
    rise(1'b0, 1'b0);
    check("idc_no_udr", 32'(cap_cnt + shf_cnt + upd_cnt), 32'd0);
`endif

    // bypass: one-bit delay through the bypass register
    load_ir(4'b1111);
    rise(1'b1, 1'b0);
    rise(1'b0, 1'b0);
    rise(1'b0, 1'b0);
    pat = 4'b1101;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    for (int i = 0; i < 4; i++) begin
      fall();
      check_tdo("byp_tdo");
      rise(1'b0, pat[i]);
    end
    fall();
    check("byp_tdo_last", 32'(bus.tdo), 32'd1);
    rise(1'b0, 1'b0);
    both(1'b1, 1'b0);
    check("coll_state", 32'(bus.tap_state), 32'h1);
    check("coll_tdo_held", 32'(bus.tdo), 32'd1);
    rise(1'b1, 1'b0);
    fall();
    rise(1'b0, 1'b0);
    check("byp_no_udr", 32'(cap_cnt + shf_cnt + upd_cnt), 32'd0);

    // user instruction: strobes and tdo from udr_tdo
    load_ir(4'b0101);
    bus.udr_tdo = 1'b1;
    rise(1'b1, 1'b0);
    rise(1'b0, 1'b0);
    rise(1'b0, 1'b0);
    fall();
    check("usr_tdo1", 32'(bus.tdo), 32'd1);
    bus.udr_tdo = 1'b0;
    rise(1'b0, 1'b1);
    fall();
    check("usr_tdo0", 32'(bus.tdo), 32'd0);
    rise(1'b0, 1'b0);
    fall();
    rise(1'b1, 1'b0);
    rise(1'b1, 1'b0);
    check("usr_upd_before_fall", 32'(upd_cnt), 32'd0);
    fall();
    rise(1'b0, 1'b0);
    check("usr_cap_cnt", 32'(cap_cnt), 32'd1);
    check("usr_shf_cnt", 32'(shf_cnt), 32'd3);
    check("usr_upd_cnt", 32'(upd_cnt), 32'd1);

    // entering Test-Logic-Reset restores the reset instruction at once
    rise(1'b1, 1'b0);
    rise(1'b1, 1'b0);
    rise(1'b1, 1'b0);
    check("tlr_entry_state", 32'(bus.tap_state), 32'hF);
    check("tlr_entry_ir", 32'(bus.ir_out), 32'(RST_IR));
    cur_ir = RST_IR;
    rise(1'b0, 1'b0);

    // asynchronous reset in the middle of a user Shift-DR
    load_ir(4'b0101);
    bus.udr_tdo = 1'b1;
    rise(1'b1, 1'b0);
    rise(1'b0, 1'b0);
    rise(1'b0, 1'b0);
    fall();
    check("pre_rst_oe", 32'(bus.tdo_oe), 32'd1);
    rise(1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", 32'(bus.tap_state), 32'hF);
    check("mid_rst_ir", 32'(bus.ir_out), 32'(RST_IR));
    check("mid_rst_tdo", 32'(bus.tdo), 32'd0);
    check("mid_rst_oe", 32'(bus.tdo_oe), 32'd0);
    check("mid_rst_udr", 32'({bus.udr_capture, bus.udr_shift, bus.udr_update}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fall();
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_no_update", 32'(upd_cnt), 32'd1);
    check("post_rst_state", 32'(bus.tap_state), 32'hF);
    check("post_rst_cap_cnt", 32'(cap_cnt), 32'd2);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
